// File: rtl/wordle_scorer.sv
// Scores one Wordle guess against a target, one letter per cycle: GREEN pass, then YELLOW pass.
// Optional WORDLE_SCORER_EARLYWIN_EN: an all-green guess skips the YELLOW pass.
//
// state  | meaning
// IDLE   | waiting for start; result/win hold last score
// GREEN  | exact-position matches, letter idx per cycle
// YELLOW | misplaced letters, lowest unused target slot first
// DONE   | result/win valid until ack
module wordle_scorer (
    input  logic        Clk,
    input  logic        reset,
    input  logic        start,
    input  logic        ack,
    input  logic [39:0] guess,
    input  logic [39:0] target,
    output logic        busy,
    output logic        done,
    output logic [9:0]  result,
    output logic        win,
    output logic        q_I,
    output logic        q_G,
    output logic        q_Y,
    output logic        q_Done
);
    localparam int NLET = 5;

    typedef enum logic [3:0] {
        S_IDLE   = 4'b0001,
        S_GREEN  = 4'b0010,
        S_YELLOW = 4'b0100,
        S_DONE   = 4'b1000
    } state_t;

    state_t          state, state_nxt;
    logic [7:0]      g   [NLET];
    logic [7:0]      t   [NLET];
    logic [1:0]      res [NLET];
    logic [NLET-1:0] used;
    logic [2:0]      idx;

    logic [7:0] g_cur, t_cur;
    logic [1:0] res_cur;
    logic       green_hit, found, last_letter, all_green;
    logic [2:0] j_sel;
`ifdef WORDLE_SCORER_EARLYWIN_EN
    logic       all_green_nxt;
`endif

    always_comb begin
        g_cur   = '0;
        t_cur   = '0;
        res_cur = '0;
        for (int i = 0; i < NLET; i++) begin
            if (idx == 3'(i)) begin
                g_cur   = g[i];
                t_cur   = t[i];
                res_cur = res[i];
            end
        end
        green_hit   = (g_cur == t_cur);
        last_letter = (idx == 3'(NLET - 1));
        // Scan high to low so the lowest free matching target slot wins.
        found = 1'b0;
        j_sel = '0;
        for (int j = NLET - 1; j >= 0; j--) begin
            if (!used[j] && (t[j] == g_cur)) begin
                found = 1'b1;
                j_sel = 3'(j);
            end
        end
        all_green = 1'b1;
        for (int i = 0; i < NLET; i++) begin
            all_green = all_green & (res[i] == 2'b10);
        end
`ifdef WORDLE_SCORER_EARLYWIN_EN
        all_green_nxt = 1'b1;
        for (int i = 0; i < NLET; i++) begin
            all_green_nxt = all_green_nxt &
                            ((res[i] == 2'b10) || ((idx == 3'(i)) && green_hit));
        end
`endif
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_GREEN;
            S_GREEN: begin
                if (last_letter) begin
`ifdef WORDLE_SCORER_EARLYWIN_EN
                    state_nxt = all_green_nxt ? S_DONE : S_YELLOW;
`else
                    state_nxt = S_YELLOW;
`endif
                end
            end
            S_YELLOW: if (last_letter) state_nxt = S_DONE;
            S_DONE:   if (ack) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NLET; i++) begin
                g[i]   <= '0;
                t[i]   <= '0;
                res[i] <= '0;
            end
            used <= '0;
            idx  <= '0;
            win  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        for (int i = 0; i < NLET; i++) begin
                            g[i]   <= guess[39 - 8*i -: 8];
                            t[i]   <= target[39 - 8*i -: 8];
                            res[i] <= 2'b00;
                        end
                        used <= '0;
                        idx  <= '0;
                        win  <= 1'b0;
                    end
                end
                S_GREEN: begin
                    for (int i = 0; i < NLET; i++) begin
                        if ((idx == 3'(i)) && green_hit) begin
                            res[i]  <= 2'b10;
                            used[i] <= 1'b1;
                        end
                    end
                    idx <= last_letter ? 3'd0 : idx + 3'd1;
`ifdef WORDLE_SCORER_EARLYWIN_EN
                    if (last_letter && all_green_nxt) win <= 1'b1;
`endif
                end
                S_YELLOW: begin
                    if ((res_cur != 2'b10) && found) begin
                        for (int i = 0; i < NLET; i++) begin
                            if (idx == 3'(i)) res[i] <= 2'b01;
                        end
                        used[j_sel] <= 1'b1;
                    end
                    idx <= last_letter ? 3'd0 : idx + 3'd1;
                    // The yellow pass never creates greens, so the current greens decide win.
                    if (last_letter) win <= all_green;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        result = '0;
        for (int i = 0; i < NLET; i++) begin
            result[9 - 2*i -: 2] = res[i];
        end
    end

    assign q_I    = state[0];
    assign q_G    = state[1];
    assign q_Y    = state[2];
    assign q_Done = state[3];
    assign busy   = q_G | q_Y;
    assign done   = q_Done;
endmodule

// File: doc/wordle_scorer.md
# wordle_scorer

Sequential scorer for one Wordle guess. It compares a 5-letter guess against the 5-letter target and produces a per-letter green/yellow/gray score with correct duplicate-letter handling. It sits between the game state machine and the display/LED logic. The game state machine pulses `start` once per guess and waits for `done` before advancing to the next guess state.

## Interface
- `NLET`, 5: letters per word; fixed, not overridable.
- `Clk` in 1: system clock, rising edge.
- `reset` in 1: reset, asynchronous, active-high.
- `start` in 1: request to score `guess`/`target`; sampled only in IDLE.
- `ack` in 1: consumer has read the result; sampled only in DONE.
- `guess` in 40: 5 ASCII bytes; letter 0 in [39:32], letter 4 in [7:0].
- `target` in 40: secret word, same packing.
- `busy` out 1: high in GREEN and YELLOW states.
- `done` out 1: high in DONE state.
- `result` out 10: 2 bits per letter, letter 0 in [9:8]; 00 gray, 01 yellow, 10 green, 11 never driven.
- `win` out 1: all five letters green; valid while `done`.
- `q_I`, `q_G`, `q_Y`, `q_Done` out 1 each: one-hot state outputs.

## Operation
- Internal registers:
  - latched `g[0:4]`, `t[0:4]` (8 bits each);
  - `used[4:0]`, marking target positions already consumed;
  - `idx[2:0]`, the letter counter.
- **IDLE.**
  - `start`=1: latch `guess`/`target`, clear `result`, `win`, `used`; set `idx`=0; go to GREEN.
  - `start`=0: stay in IDLE; `result`/`win` hold their last values.
- **GREEN** (one letter per cycle):
  - if `g[idx]==t[idx]`: `result[idx]`=10 and `used[idx]`=1.
  - `idx` increments; after `idx`=4, set `idx`=0 and go to YELLOW.
- **YELLOW** (one letter per cycle):
  - if `result[idx]`≠10, find the lowest j in 0..4 with `used[j]`=0 and `t[j]==g[idx]`.
  - If such a j exists: `result[idx]`=01 and `used[j]`=1. Otherwise the letter stays 00.
  - After `idx`=4, go to DONE and set `win`=(`result`==10'b1010101010).
- **DONE.** Hold `result`/`win`. On `ack`=1, go to IDLE.
- Comparison is raw 8-bit equality: no case folding and no validity check.
- Duplicate rule: greens consume their target position first. Yellows are then allocated left to right, and each target letter is consumed at most once.
- `start` outside IDLE is ignored, and inputs are not re-latched. `ack` outside DONE is ignored.
- `ack` and `start` both high in DONE: return to IDLE only; `start` is not accepted that cycle.

## Timing
- Reset values:
  - state IDLE (`q_I`=1, other state outputs 0);
  - `busy`=0, `done`=0, `result`=0, `win`=0;
  - `used`=0, `idx`=0.
- Reset during any state forces IDLE on the next evaluation. Any partial result is discarded and cleared to 0.
- With `start` accepted at edge E0:
  - `busy`=1 after E0;
  - GREEN occupies edges E1–E5 and YELLOW occupies E6–E10;
  - `done`=1 after E10, giving a latency of 10 cycles.
- `done` stays high until the edge at which `ack` is sampled high. `done` falls after that edge.
- After DONE→IDLE, the earliest next `start` acceptance is the following edge.
- All outputs are registered; none depend combinationally on inputs.

## Configuration
- Macro: `WORDLE_SCORER_EARLYWIN_EN`.
- Defined: at the end of GREEN, if all five letters are green, skip YELLOW and go straight to DONE with `win`=1. Win latency is 5 cycles (`done` after E5). Non-winning guesses still take 10 cycles.
- Undefined: YELLOW always runs, so latency is always 10 cycles. `result`/`win` values are identical to the defined case.

## Test plan
- Target "CRANE", guess "CRANE", `start` pulse. Expect:
  - `result`=10'b1010101010, `win`=1;
  - `done` after E10, or after E5 with `WORDLE_SCORER_EARLYWIN_EN`.
- Target "CRANE", guess "EERIE" → `result`=10'b0000010010, `win`=0. Checks that a green consumes the only E.
- Target "ABIDE", guess "SPEED" → `result`=10'b0000010001. Checks that the second E is gray and D is yellow.
- Handshake:
  - `start` pulses during GREEN are ignored, with no result change;
  - `done` holds for 20 cycles without `ack`;
  - `ack`+`start` together in DONE leads to IDLE with the new start not accepted.
- Reset asserted mid-YELLOW → next cycle IDLE, with `result`=0, `busy`=0, `done`=0. A subsequent `start` scores correctly.
- Target "AAAAA", guess "BBBBB" → `result`=0, `win`=0, latency 10 in both configurations.
